// File: rtl/cavlc_bit_packer.sv
// Packs right-aligned CAVLC code/length pairs MSB-first into 32-bit words; flush appends the stop bit and emits a padded final word.
// Latency: a codeword that fills a word shows up on word_o one cycle after it is accepted, if the output register is free.
// Backpressure: word_ready_i low holds the output register; code_ready_o drops once more than 32 bits are pending.
module cavlc_bit_packer #(
  parameter int OUT_W    = 32,
  parameter bit STOP_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid_i,
  output logic             code_ready_o,
  input  logic [OUT_W-1:0] code_i,
  input  logic [5:0]       code_len_i,
  input  logic             flush_i,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [OUT_W-1:0] word_o,
  output logic [2:0]       word_bytes_o,
  output logic             word_last_o,
  output logic             busy_o,
  output logic             flush_done_o,
  output logic [31:0]      bit_count_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [2*OUT_W-1:0]  acc;
  logic [6:0]          fcnt;
  logic [31:0]         bit_count;
  logic [OUT_W-1:0]    word;
  logic [2:0]          word_bytes;
  logic                word_last;
  logic                word_valid;
  logic                flush_done;

  logic [5:0]          len_sat;
  logic [OUT_W-1:0]    code_mask;
  logic [2*OUT_W-1:0]  code_ext;
  logic                free;
  logic                emit;
  logic [2*OUT_W-1:0]  acc_e;
  logic [6:0]          fcnt_e;
  logic [6:0]          shamt;
  logic [2*OUT_W-1:0]  ins;
  logic [2*OUT_W-1:0]  stop_vec;
  logic                accept;
  logic                flush_take;
  logic [6:0]          stop_add;
  logic [2:0]          tail_bytes;

  assign code_ready_o = (state == RUN) && (fcnt <= 7'd32);
  assign busy_o       = (state != RUN);
  assign word_o       = word;
  assign word_bytes_o = word_bytes;
  assign word_last_o  = word_last;
  assign word_valid_o = word_valid;
  assign flush_done_o = flush_done;
  assign bit_count_o  = bit_count;

  // Emit-then-append datapath: the incoming code lands right after the bits that survive this cycle's emit.
  always_comb begin
    len_sat    = (code_len_i > 6'd32) ? 6'd32 : code_len_i;
    code_mask  = (len_sat == 6'd32) ? '1 : ((32'd1 << len_sat) - 32'd1);
    code_ext   = {32'd0, code_i & code_mask};
    free       = !word_valid || word_ready_i;
    emit       = free && (fcnt >= 7'd32);
    acc_e      = emit ? {acc[OUT_W-1:0], 32'd0} : acc;
    fcnt_e     = emit ? (fcnt - 7'd32) : fcnt;
    // 64 - fill - len; a zero-length code shifts fully out (shift of 64 yields zero).
    shamt      = 7'd64 - fcnt_e - {1'b0, len_sat};
    ins        = code_ext << shamt;
    stop_vec   = STOP_BIT ? (64'h8000_0000_0000_0000 >> fcnt_e) : 64'd0;
    stop_add   = STOP_BIT ? 7'd1 : 7'd0;
    accept     = code_valid_i && code_ready_o;
    flush_take = (state == RUN) && flush_i && !code_valid_i && (fcnt < 7'd64);
    tail_bytes = 3'((fcnt + 7'd7) >> 3);
  end

  // Accumulator, output register and RUN/DRAIN/DONE control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      acc        <= '0;
      fcnt       <= '0;
      bit_count  <= '0;
      word       <= '0;
      word_bytes <= '0;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (word_valid && word_ready_i) word_valid <= 1'b0;
      case (state)
        RUN: begin
          if (emit) begin
            word       <= acc[2*OUT_W-1:OUT_W];
            word_bytes <= 3'd4;
            word_last  <= 1'b0;
            word_valid <= 1'b1;
          end
          if (accept) begin
            acc       <= acc_e | ins;
            fcnt      <= fcnt_e + {1'b0, len_sat};
            bit_count <= bit_count + {26'd0, len_sat};
          end else if (flush_take) begin
            acc       <= acc_e | stop_vec;
            fcnt      <= fcnt_e + stop_add;
            bit_count <= bit_count + {25'd0, stop_add};
            state     <= DRAIN;
          end else begin
            acc  <= acc_e;
            fcnt <= fcnt_e;
          end
        end
        DRAIN: begin
          if (fcnt == 7'd0) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end else if (free) begin
            word       <= acc[2*OUT_W-1:OUT_W];
            word_valid <= 1'b1;
            if (fcnt >= 7'd32) begin
              // Full word; it is the last one only if nothing remains behind it.
              word_bytes <= 3'd4;
              word_last  <= (fcnt == 7'd32);
              acc        <= acc_e;
              fcnt       <= fcnt_e;
              if (fcnt == 7'd32) begin
                state      <= DONE;
                flush_done <= 1'b1;
              end
            end else begin
              // Partial tail word; bits below the fill count are already zero.
              word_bytes <= tail_bytes;
              word_last  <= 1'b1;
              acc        <= '0;
              fcnt       <= '0;
              state      <= DONE;
              flush_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Directed bench for cavlc_bit_packer: packing, flush tails, straddling, backpressure and mid-run reset.
// Words handed over (valid & ready) are captured into a queue and compared against hand-computed values.
// Inputs are driven away from the rising edge; DUT outputs are sampled on the falling edge.
module tb_cavlc_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        code_valid_i = 1'b0;
  logic        code_ready_o;
  logic [31:0] code_i = '0;
  logic [5:0]  code_len_i = '0;
  logic        flush_i = 1'b0;
  logic        word_valid_o;
  logic        word_ready_i = 1'b1;
  logic [31:0] word_o;
  logic [2:0]  word_bytes_o;
  logic        word_last_o;
  logic        busy_o;
  logic        flush_done_o;
  logic [31:0] bit_count_o;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [35:0] wq[$];

  cavlc_bit_packer #(.OUT_W(32), .STOP_BIT(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .code_i       (code_i),
    .code_len_i   (code_len_i),
    .flush_i      (flush_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_o       (word_o),
    .word_bytes_o (word_bytes_o),
    .word_last_o  (word_last_o),
    .busy_o       (busy_o),
    .flush_done_o (flush_done_o),
    .bit_count_o  (bit_count_o)
  );

  always #5 clk = ~clk;

  // Capture each handed-over word and count flush completions.
  always @(posedge clk) begin
    if (!rst && word_valid_o && word_ready_i)
      wq.push_back({word_last_o, word_bytes_o, word_o});
    if (!rst && flush_done_o)
      done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    code_valid_i = 1'b0;
    flush_i = 1'b0;
    word_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic send(input logic [31:0] c, input logic [5:0] l);
    int n = 0;
    @(negedge clk);
    code_valid_i = 1'b1;
    code_i = c;
    code_len_i = l;
    while (!code_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, code_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    code_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    while (!busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("flush_busy", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("flush_done_once", done_cnt - d0, 32'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] w, input logic [2:0] b, input logic l);
    logic [35:0] e;
    chk({tag, "_avail"}, {31'd0, (wq.size() > 0)}, 32'd1);
    if (wq.size() > 0) begin
      e = wq.pop_front();
      chk({tag, "_word"}, e[31:0], w);
      chk({tag, "_bytes"}, {29'd0, e[34:32]}, {29'd0, b});
      chk({tag, "_last"}, {31'd0, e[35]}, {31'd0, l});
    end
  endtask

  initial begin
    int d0;

    // Reset state
    do_reset();
    chk("rst_wvalid", {31'd0, word_valid_o}, 32'd0);
    chk("rst_cready", {31'd0, code_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_bitcnt", bit_count_o, 32'd0);
    chk("rst_fdone", {31'd0, flush_done_o}, 32'd0);

    // Four bytes, with a zero-length code and junk above len in between
    send(32'hFFFF_FFAB, 6'd8);
    send(32'hFFFF_FFFF, 6'd0);
    send(32'h0000_00CD, 6'd8);
    send(32'h0000_00EF, 6'd8);
    send(32'h0000_0001, 6'd8);
    repeat (4) @(negedge clk);
    chk("pack4_count", wq.size(), 32'd1);
    pop_chk("pack4", 32'hABCD_EF01, 3'd4, 1'b0);
    chk("pack4_bitcnt", bit_count_o, 32'd32);
    // Flush at fcnt 0: only the stop bit goes out
    do_flush();
    pop_chk("stoponly", 32'h8000_0000, 3'd1, 1'b1);
    chk("stoponly_bitcnt", bit_count_o, 32'd33);

    // Short flush: 101 + 00011 + stop
    do_reset();
    send(32'h0000_0005, 6'd3);
    send(32'h0000_0003, 6'd5);
    do_flush();
    chk("short_count", wq.size(), 32'd1);
    pop_chk("short", 32'hA380_0000, 3'd2, 1'b1);
    chk("short_bitcnt", bit_count_o, 32'd9);
    chk("short_busy", {31'd0, busy_o}, 32'd0);
    chk("short_cready", {31'd0, code_ready_o}, 32'd1);

    // Straddle across a word boundary
    do_reset();
    send(32'h000A_BCDE, 6'd20);
    send(32'h0001_2345, 6'd20);
    do_flush();
    chk("straddle_count", wq.size(), 32'd2);
    pop_chk("straddle0", 32'hABCD_E123, 3'd4, 1'b0);
    pop_chk("straddle1", 32'h4580_0000, 3'd2, 1'b1);
    chk("straddle_bitcnt", bit_count_o, 32'd41);

    // 31 bits + stop fill exactly one word, which is also the last
    do_reset();
    send(32'h0000_0001, 6'd31);
    do_flush();
    chk("exact_count", wq.size(), 32'd1);
    pop_chk("exact", 32'h0000_0003, 3'd4, 1'b1);

    // Backpressure; the middle code uses an oversize length treated as 32
    do_reset();
    word_ready_i = 1'b0;
    send(32'hFFFF_FFFF, 6'd32);
    send(32'h1234_5678, 6'd40);
    send(32'h0000_0000, 6'd32);
    repeat (3) @(negedge clk);
    chk("bp_cready", {31'd0, code_ready_o}, 32'd0);
    chk("bp_wvalid", {31'd0, word_valid_o}, 32'd1);
    chk("bp_hold_word", word_o, 32'hFFFF_FFFF);
    chk("bp_hold_bytes", {29'd0, word_bytes_o}, 32'd4);
    chk("bp_none_taken", wq.size(), 32'd0);
    word_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_count", wq.size(), 32'd3);
    pop_chk("bp0", 32'hFFFF_FFFF, 3'd4, 1'b0);
    pop_chk("bp1", 32'h1234_5678, 3'd4, 1'b0);
    pop_chk("bp2", 32'h0000_0000, 3'd4, 1'b0);
    chk("bp_bitcnt", bit_count_o, 32'd96);
    chk("bp_cready_after", {31'd0, code_ready_o}, 32'd1);

    // Reset with 40 bits pending and a word held
    do_reset();
    word_ready_i = 1'b0;
    send(32'hFFFF_FFFF, 6'd32);
    send(32'h1234_5678, 6'd32);
    send(32'h0000_00AA, 6'd8);
    @(negedge clk);
    chk("mid_pre_cready", {31'd0, code_ready_o}, 32'd0);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_wvalid", {31'd0, word_valid_o}, 32'd0);
    chk("mid_cready", {31'd0, code_ready_o}, 32'd1);
    chk("mid_bitcnt", bit_count_o, 32'd0);
    chk("mid_last", {31'd0, word_last_o}, 32'd0);
    chk("mid_fdone", {31'd0, flush_done_o}, 32'd0);
    rst = 1'b0;
    word_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_no_words", wq.size(), 32'd0);
    chk("mid_no_done", done_cnt - d0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
